count_updn_fsm: RTL and testbench

COUNT_UPDN_FSM -- requirements
Module: count_updn_fsm

---
 rtl/count_updn_fsm.sv | 85 ++++++++
 tb/tb_count_updn_fsm.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/count_updn_fsm.sv
// Up/down modulo-MOD counter with optional saturation, parallel load and a
// registered terminal-count pulse; the control FSM state is exported on ST.
module count_updn_fsm #(
    parameter int              WIDTH = 8,
    parameter longint unsigned MOD   = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             load,
    input  logic             up,
    input  logic             sat,
    input  logic [WIDTH-1:0] CNT_In,
    output logic [WIDTH-1:0] CNT,
    output logic             TC,
    output logic [2:0]       ST
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        UP   = 3'b001,
        DN   = 3'b010,
        HOLD = 3'b011,
        SAT  = 3'b100
    } state_t;

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 64'd1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;
    logic             at_top, at_bot;

    assign at_top = (CNT == MAXV);
    assign at_bot = (CNT == '0);
    assign ST     = state;

    always_ff @(posedge clk) begin
        state <= state_nxt;
        CNT   <= cnt_nxt;
        TC    <= tc_nxt;
    end

    // Priority res > load > EN; TC defaults low so every unlisted edge clears it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = CNT;
        tc_nxt    = 1'b0;
        if (res) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE, UP, DN, HOLD, SAT: begin
                    if (load) begin
                        cnt_nxt   = (CNT_In > MAXV) ? MAXV : CNT_In;
                        state_nxt = HOLD;
                    end else if (!EN) begin
                        state_nxt = (state == IDLE) ? IDLE : HOLD;
                    end else if (up) begin
                        if (at_top && sat) begin
                            state_nxt = SAT;
                            tc_nxt    = (state != SAT);
                        end else begin
                            cnt_nxt   = at_top ? '0 : CNT + WIDTH'(1);
                            tc_nxt    = at_top;
                            state_nxt = UP;
                        end
                    end else begin
                        if (at_bot && sat) begin
                            state_nxt = SAT;
                            tc_nxt    = (state != SAT);
                        end else begin
                            cnt_nxt   = at_bot ? MAXV : CNT - WIDTH'(1);
                            tc_nxt    = at_bot;
                            state_nxt = DN;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_updn_fsm.sv
// Bench for count_updn_fsm: a MOD=10 instance and a default-MOD 4-bit instance
// driven together, checked against an arithmetic reference model plus directed constants.
module tb_count_updn_fsm;

    logic       clk = 1'b0;
    logic       res, EN, load, up, sat;
    logic [7:0] cnt_in;
    logic [7:0] cnt_a;
    logic       tc_a;
    logic [2:0] st_a;
    logic [3:0] cnt_b;
    logic       tc_b;
    logic [2:0] st_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int cnt;
        int st;
        int tc;
    } mstate_t;

    mstate_t ma, mb;

    always #5 clk = ~clk;

    count_updn_fsm #(.WIDTH(8), .MOD(10)) dut_a (
        .clk(clk), .res(res), .EN(EN), .load(load), .up(up), .sat(sat),
        .CNT_In(cnt_in), .CNT(cnt_a), .TC(tc_a), .ST(st_a)
    );

    count_updn_fsm #(.WIDTH(4)) dut_b (
        .clk(clk), .res(res), .EN(EN), .load(load), .up(up), .sat(sat),
        .CNT_In(cnt_in[3:0]), .CNT(cnt_b), .TC(tc_b), .ST(st_b)
    );

    // State codes: 0 idle, 1 counting up, 2 counting down, 3 hold, 4 saturated.
    function automatic mstate_t mstep(mstate_t m, int mod, bit r, bit ld, bit en,
                                      bit u, bit s, int cin);
        mstate_t n;
        int lim;
        n    = m;
        n.tc = 0;
        if (r) begin
            n.cnt = 0;
            n.st  = 0;
        end else if (ld) begin
            n.cnt = (cin > mod - 1) ? mod - 1 : cin;
            n.st  = 3;
        end else if (!en) begin
            n.st = (m.st == 0) ? 0 : 3;
        end else begin
            lim = u ? mod - 1 : 0;
            if (m.cnt == lim && s) begin
                n.st = 4;
                n.tc = (m.st != 4) ? 1 : 0;
            end else begin
                n.cnt = u ? (m.cnt + 1) % mod : (m.cnt + mod - 1) % mod;
                n.st  = u ? 1 : 2;
                n.tc  = (m.cnt == lim) ? 1 : 0;
            end
        end
        return n;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(bit r, bit ld, bit en, bit u, bit s, logic [7:0] cin);
        res = r; load = ld; EN = en; up = u; sat = s; cnt_in = cin;
        @(posedge clk);
        ma = mstep(ma, 10, r, ld, en, u, s, int'(cin));
        mb = mstep(mb, 16, r, ld, en, u, s, int'(cin[3:0]));
        #1;
        chk("a_cnt_model", 32'(cnt_a), 32'(ma.cnt));
        chk("a_tc_model",  32'(tc_a),  32'(ma.tc));
        chk("a_st_model",  32'(st_a),  32'(ma.st));
        chk("b_cnt_model", 32'(cnt_b), 32'(mb.cnt));
        chk("b_tc_model",  32'(tc_b),  32'(mb.tc));
        chk("b_st_model",  32'(st_b),  32'(mb.st));
    endtask

    task automatic expect_a(string tag, int c, int t, int s);
        chk({tag, "_cnt"}, 32'(cnt_a), 32'(c));
        chk({tag, "_tc"},  32'(tc_a),  32'(t));
        chk({tag, "_st"},  32'(st_a),  32'(s));
    endtask

    initial begin
        bit r, ld, en, u, s;
        logic [7:0] cin;
        ma = '{cnt: 0, st: 0, tc: 0};
        mb = '{cnt: 0, st: 0, tc: 0};
        res = 1'b0; load = 1'b0; EN = 1'b0; up = 1'b0; sat = 1'b0; cnt_in = '0;
        #2;

        // reset with load pending
        step(1, 1, 0, 0, 0, 8'hAA); expect_a("rst1", 0, 0, 0);
        step(1, 1, 0, 0, 0, 8'hAA); expect_a("rst2", 0, 0, 0);
        step(0, 0, 0, 0, 0, 8'h00); expect_a("idle_stay", 0, 0, 0);

        // wrap up
        step(0, 1, 0, 0, 0, 8'd8); expect_a("ld8", 8, 0, 3);
        step(0, 0, 1, 1, 0, 8'd0); expect_a("wup1", 9, 0, 1);
        step(0, 0, 1, 1, 0, 8'd0); expect_a("wup2", 0, 1, 1);
        step(0, 0, 1, 1, 0, 8'd0); expect_a("wup3", 1, 0, 1);

        // wrap down
        step(0, 1, 0, 0, 0, 8'd1); expect_a("ld1", 1, 0, 3);
        step(0, 0, 1, 0, 0, 8'd0); expect_a("wdn1", 0, 0, 2);
        step(0, 0, 1, 0, 0, 8'd0); expect_a("wdn2", 9, 1, 2);

        // saturate then leave
        step(0, 1, 0, 0, 1, 8'd8); expect_a("sld8", 8, 0, 3);
        step(0, 0, 1, 1, 1, 8'd0); expect_a("sat1", 9, 0, 1);
        step(0, 0, 1, 1, 1, 8'd0); expect_a("sat2", 9, 1, 4);
        step(0, 0, 1, 1, 1, 8'd0); expect_a("sat3", 9, 0, 4);
        step(0, 0, 1, 1, 1, 8'd0); expect_a("sat4", 9, 0, 4);
        step(0, 0, 1, 0, 1, 8'd0); expect_a("satdn", 8, 0, 2);

        // sat dropped while saturated wraps on next count toward limit
        step(0, 0, 1, 1, 1, 8'd0); expect_a("s2a", 9, 0, 1);
        step(0, 0, 1, 1, 1, 8'd0); expect_a("s2b", 9, 1, 4);
        step(0, 0, 1, 1, 0, 8'd0); expect_a("s2wrap", 0, 1, 1);

        // load beats EN, clamped; then hold
        step(0, 1, 1, 1, 0, 8'd200); expect_a("clamp", 9, 0, 3);
        step(0, 0, 0, 1, 0, 8'd0);   expect_a("hold", 9, 0, 3);

        // reset mid-count
        step(0, 1, 0, 0, 0, 8'd4); expect_a("ld4", 4, 0, 3);
        step(0, 0, 1, 1, 0, 8'd0); expect_a("c5", 5, 0, 1);
        step(1, 0, 1, 1, 0, 8'd0); expect_a("midrst", 0, 0, 0);
        step(0, 0, 1, 1, 0, 8'd0); expect_a("after", 1, 0, 1);

        // reset while saturated leaves no TC
        step(0, 1, 0, 0, 1, 8'd0); expect_a("ld0", 0, 0, 3);
        step(0, 0, 1, 0, 1, 8'd0); expect_a("satlo", 0, 1, 4);
        step(1, 0, 1, 0, 1, 8'd0); expect_a("satrst", 0, 0, 0);

        s = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(31) == 0);
            ld  = ($urandom_range(7) == 0);
            en  = ($urandom_range(3) != 0);
            u   = ($urandom_range(3) != 0) ^ (i[6] == 1'b1);
            if ($urandom_range(15) == 0) s = ~s;
            cin = ($urandom_range(1) == 0) ? 8'($urandom_range(15)) : 8'($urandom);
            step(r, ld, en, u, s, cin);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
